// File: rtl/phase_ramp_ctrl.sv
// rtl/phase_ramp_ctrl.sv - ramps the phase-shift generator delay toward a clamped target,
// updating only on the generator period boundary so the shifted clock never glitches.
module phase_ramp_ctrl #(
   parameter int PERIOD      = 1250,
   parameter int HALF        = 625,
   parameter int RESET_DELAY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [10:0] tgt_delay,
   input  logic               tgt_valid,
   output logic               tgt_ready,
   input  logic [7:0]         step_size,
   input  logic               hold,
   output logic signed [10:0] delay_out,
   output logic               sync_out,
   output logic               busy,
   output logic               at_target,
   output logic               err_clamp
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RAMP   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   localparam logic signed [11:0] LP_MAX   = 12'(HALF);
   localparam logic signed [11:0] LP_MIN   = 12'(1 - HALF);
   localparam logic [10:0]        LP_PLAST = 11'(PERIOD - 1);

   logic [10:0]        r_pcnt;
   logic [1:0]         r_state;
   logic signed [10:0] r_delay;
   logic signed [11:0] r_tgt_q;
   logic [7:0]         r_step_q;
   logic               r_at_target;
   logic               r_err_clamp;

   logic               w_ptick;
   logic               w_accept;
   logic signed [11:0] w_tgt_ext;
   logic signed [11:0] w_clamped;
   logic               w_clamp_hit;
   logic signed [11:0] w_delay_ext;
   logic signed [11:0] w_diff;
   logic signed [11:0] w_abs_diff;
   logic signed [11:0] w_step_ext;
   logic signed [11:0] w_stepped;
   logic               w_ramp_done;

   assign w_ptick     = (r_pcnt == LP_PLAST);
   assign tgt_ready   = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign w_accept    = tgt_valid & tgt_ready;
   assign sync_out    = (r_pcnt == 11'd0);
   assign delay_out   = r_delay;
   assign at_target   = r_at_target;
   assign err_clamp   = r_err_clamp;
   assign w_tgt_ext   = {tgt_delay[10], tgt_delay};
   assign w_delay_ext = {r_delay[10], r_delay};
   assign w_step_ext  = {4'b0000, r_step_q};

   always_comb begin
      w_clamped = w_tgt_ext;
      if (w_tgt_ext > LP_MAX) begin
         w_clamped = LP_MAX;
      end else if (w_tgt_ext < LP_MIN) begin
         w_clamped = LP_MIN;
      end else if (w_tgt_ext == 12'sd0) begin
         w_clamped = 12'sd1;
      end
      w_clamp_hit = (w_clamped != w_tgt_ext);
   end

   // One ramp step; a step landing on 0 skips past it since 0 is not a legal delay.
   always_comb begin
      w_diff      = r_tgt_q - w_delay_ext;
      w_abs_diff  = w_diff[11] ? -w_diff : w_diff;
      w_ramp_done = (w_abs_diff <= w_step_ext);
      w_stepped   = w_diff[11] ? (w_delay_ext - w_step_ext) : (w_delay_ext + w_step_ext);
      if (w_stepped == 12'sd0) begin
         w_stepped = w_diff[11] ? -12'sd1 : 12'sd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= 11'd0;
      end else if (w_ptick) begin
         r_pcnt <= 11'd0;
      end else begin
         r_pcnt <= r_pcnt + 11'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_delay     <= 11'(RESET_DELAY);
         r_tgt_q     <= 12'(RESET_DELAY);
         r_step_q    <= 8'd1;
         r_at_target <= 1'b0;
         r_err_clamp <= 1'b0;
      end else begin
         r_at_target <= 1'b0;
         r_err_clamp <= w_accept & w_clamp_hit;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tgt_q  <= w_clamped;
                  r_step_q <= (step_size == 8'd0) ? 8'd1 : step_size;
                  r_state  <= (w_clamped == w_delay_ext) ? S_SETTLE : S_RAMP;
               end
            end
            S_RAMP: begin
               if (w_ptick && !hold) begin
                  if (w_ramp_done) begin
                     r_delay <= 11'(r_tgt_q);
                     r_state <= S_SETTLE;
                  end else begin
                     r_delay <= 11'(w_stepped);
                  end
               end
            end
            S_SETTLE: begin
               if (w_ptick) begin
                  r_at_target <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_ramp_ctrl.sv
// tb/tb_phase_ramp_ctrl.sv - directed bench for phase_ramp_ctrl at PERIOD=16, HALF=8.
module tb_phase_ramp_ctrl;

   localparam int P = 16;
   localparam int H = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [10:0] tgt_delay = 11'sd0;
   logic               tgt_valid = 1'b0;
   logic               tgt_ready;
   logic [7:0]         step_size = 8'd0;
   logic               hold = 1'b0;
   logic signed [10:0] delay_out;
   logic               sync_out;
   logic               busy;
   logic               at_target;
   logic               err_clamp;

   int n_tests = 0;
   int n_fail  = 0;

   phase_ramp_ctrl #(.PERIOD(P), .HALF(H), .RESET_DELAY(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgt_delay (tgt_delay),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .step_size (step_size),
      .hold      (hold),
      .delay_out (delay_out),
      .sync_out  (sync_out),
      .busy      (busy),
      .at_target (at_target),
      .err_clamp (err_clamp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge that shows sync_out (first cycle of a period).
   task automatic next_period();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!sync_out && k < 64);
      if (!sync_out) begin
         n_tests++;
         n_fail++;
         $error("FAIL period_timeout: observed no sync_out within %0d cycles", k);
      end
   endtask

   task automatic request(input int d, input int s);
      tgt_delay = 11'(d);
      step_size = 8'(s);
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
   endtask

   task automatic step_to(input string tag, input int exp);
      next_period();
      check(tag, int'(delay_out), exp);
   endtask

   task automatic settle(input string tag, input int exp);
      next_period();
      check({tag, "_at_target"}, int'(at_target), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_ready"}, int'(tgt_ready), 1);
      check({tag, "_final"}, int'(delay_out), exp);
      @(negedge clk);
      check({tag, "_at_target_off"}, int'(at_target), 0);
   endtask

   initial begin
      int cnt;
      int k;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_delay", int'(delay_out), 1);
      check("rst_sync", int'(sync_out), 1);
      check("rst_ready", int'(tgt_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_at_target", int'(at_target), 0);
      check("rst_err_clamp", int'(err_clamp), 0);
      rst_n = 1'b1;

      cnt = 0;
      for (int i = 0; i < 2 * P; i++) begin
         @(negedge clk);
         if (sync_out) cnt++;
      end
      check("idle_sync_count", cnt, 2);
      check("idle_sync_last", int'(sync_out), 1);
      check("idle_delay", int'(delay_out), 1);
      check("idle_busy", int'(busy), 0);

      // Decreasing ramp through zero: 1 -> -1 skips 0.
      request(-5, 1);
      check("a_busy", int'(busy), 1);
      check("a_ready", int'(tgt_ready), 0);
      check("a_err", int'(err_clamp), 0);
      check("a_hold_val", int'(delay_out), 1);
      step_to("a_s1", -1);
      step_to("a_s2", -2);
      step_to("a_s3", -3);
      step_to("a_s4", -4);
      step_to("a_s5", -5);
      check("a_busy_settle", int'(busy), 1);
      settle("a", -5);

      // Increasing ramp through zero: -5 + 5 -> +1.
      request(7, 5);
      step_to("b_s1", 1);
      step_to("b_s2", 6);
      step_to("b_s3", 7);
      settle("b", 7);

      // Over-range target clamps to HALF; requests during RAMP are refused.
      request(700, 0);
      check("c_err", int'(err_clamp), 1);
      @(negedge clk);
      check("c_err_off", int'(err_clamp), 0);
      tgt_delay = -11'sd3;
      tgt_valid = 1'b1;
      check("c_ready_ramp", int'(tgt_ready), 0);
      step_to("c_s1", H);
      check("c_ready_settle", int'(tgt_ready), 0);
      tgt_valid = 1'b0;
      settle("c", H);

      // Zero target clamps to +1.
      request(0, 3);
      check("d_err", int'(err_clamp), 1);
      step_to("d_s1", 5);
      step_to("d_s2", 2);
      step_to("d_s3", 1);
      settle("d", 1);

      // Hold freezes the ramp for three period boundaries.
      request(-7, 2);
      check("e_err", int'(err_clamp), 0);
      step_to("e_s1", -1);
      step_to("e_s2", -3);
      hold = 1'b1;
      step_to("e_h1", -3);
      step_to("e_h2", -3);
      step_to("e_h3", -3);
      check("e_busy_hold", int'(busy), 1);
      hold = 1'b0;
      step_to("e_s3", -5);
      step_to("e_s4", -7);
      settle("e", -7);

      // Asynchronous reset mid-ramp, mid-period.
      request(7, 2);
      step_to("f_s1", -5);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("f_rst_delay", int'(delay_out), 1);
      check("f_rst_busy", int'(busy), 0);
      check("f_rst_ready", int'(tgt_ready), 1);
      check("f_rst_sync", int'(sync_out), 1);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!sync_out && k < 40);
      check("f_pcnt_restart", k, P);

      // Accept in a ptick cycle: no step at that same edge.
      repeat (P - 1) @(negedge clk);
      request(7, 2);
      check("g_sync", int'(sync_out), 1);
      check("g_no_step", int'(delay_out), 1);
      check("g_busy", int'(busy), 1);
      step_to("g_s1", 3);
      step_to("g_s2", 5);
      step_to("g_s3", 7);
      settle("g", 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
